// File: rtl/cr_prefix_attach_pfetch.sv
// Prefix fetch engine for the prefix-attach path.
// Reads one PHD or one PFD record word-by-word from the header/data memories.
// Each returned word is flagged with a data-valid strobe and folded into a
// CRC-32. The transfer closes with a one-cycle end-of-transfer pulse that
// carries the final CRC.
module cr_prefix_attach_pfetch #(
  parameter int PHD_WORDS = 8,
  parameter int PFD_WORDS = 16,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              insert_phd_req,
  input  logic              insert_pfd_req,
  input  logic              insert_phd_inwrk,
  input  logic              insert_pfd_inwrk,
  input  logic [5:0]        prefix_num,
  input  logic [63:0]       phd_mem_dout,
  input  logic [63:0]       pfd_mem_dout,
  output logic              phd_mem_rd,
  output logic              pfd_mem_rd,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              phd_dout_valid,
  output logic              pfd_dout_valid,
  output logic              phd_eot,
  output logic              pfd_eot,
  output logic [31:0]       phd_crc,
  output logic [31:0]       pfd_crc
);

  localparam int MAX_WORDS = (PFD_WORDS > PHD_WORDS) ? PFD_WORDS : PHD_WORDS;
  localparam int IDX_W     = $clog2(MAX_WORDS) + 1;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, EOT, DONE} state_t;

  state_t           state;
  logic             sel;        // 0 = PHD transfer, 1 = PFD transfer
  logic [5:0]       pnum;
  logic [IDX_W-1:0] idx;
  logic [31:0]      crc_reg;

  logic             start_phd;
  logic             start_pfd;
  logic             sel_req;
  logic             data_valid;
  logic [63:0]      rd_data;
  logic [31:0]      crc_upd;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] idx_inc;

  // Reflected CRC-32 over 64 bits; bit 0 first is the same as LSB byte first
  // with each byte processed LSB first.
  function automatic logic [31:0] crc64(input logic [31:0] c, input logic [63:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 64; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // PFD records are laid out back to back, PFD_WORDS words per prefix.
  function automatic logic [ADDR_W-1:0] rd_addr(input logic s, input logic [5:0] pn,
                                                input logic [IDX_W-1:0] i);
    if (s) begin
      return ADDR_W'(pn) * ADDR_W'(PFD_WORDS) + ADDR_W'(i);
    end
    return ADDR_W'(i);
  endfunction

  assign start_phd  = insert_phd_req & insert_phd_inwrk;
  assign start_pfd  = insert_pfd_req & insert_pfd_inwrk;
  assign sel_req    = sel ? insert_pfd_req : insert_phd_req;
  assign data_valid = phd_dout_valid | pfd_dout_valid;
  assign rd_data    = sel ? pfd_mem_dout : phd_mem_dout;
  assign crc_upd    = crc64(crc_reg, rd_data);
  assign last_idx   = sel ? IDX_W'(PFD_WORDS - 1) : IDX_W'(PHD_WORDS - 1);
  assign idx_inc    = idx + IDX_W'(1);

  // Transfer sequencer: read issue, valid pipeline, CRC accumulation and EOT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      sel            <= 1'b0;
      pnum           <= '0;
      idx            <= '0;
      crc_reg        <= '0;
      phd_mem_rd     <= 1'b0;
      pfd_mem_rd     <= 1'b0;
      mem_rd_addr    <= '0;
      phd_dout_valid <= 1'b0;
      pfd_dout_valid <= 1'b0;
      phd_eot        <= 1'b0;
      pfd_eot        <= 1'b0;
      phd_crc        <= '0;
      pfd_crc        <= '0;
    end else begin
      // Memory latency is one cycle, so data-valid is the read enable delayed.
      phd_dout_valid <= phd_mem_rd;
      pfd_dout_valid <= pfd_mem_rd;
      phd_eot        <= 1'b0;
      pfd_eot        <= 1'b0;
      if (data_valid) begin
        crc_reg <= crc_upd;
      end

      case (state)
        IDLE: begin
          if (start_phd | start_pfd) begin
            // PHD wins when both start conditions are present.
            sel         <= ~start_phd;
            pnum        <= prefix_num;
            idx         <= '0;
            crc_reg     <= 32'hFFFF_FFFF;
            phd_mem_rd  <= start_phd;
            pfd_mem_rd  <= ~start_phd;
            mem_rd_addr <= rd_addr(~start_phd, prefix_num, '0);
            state       <= READ;
          end
        end

        READ: begin
          if (!sel_req) begin
            phd_mem_rd <= 1'b0;
            pfd_mem_rd <= 1'b0;
            state      <= IDLE;
          end else if (idx == last_idx) begin
            phd_mem_rd <= 1'b0;
            pfd_mem_rd <= 1'b0;
            state      <= DRAIN;
          end else begin
            idx         <= idx_inc;
            mem_rd_addr <= rd_addr(sel, pnum, idx_inc);
          end
        end

        DRAIN: begin
          // The last word is valid this cycle, so crc_upd is the final CRC.
          if (!sel_req) begin
            state <= IDLE;
          end else begin
            phd_eot <= ~sel;
            pfd_eot <= sel;
            if (sel) begin
              pfd_crc <= ~crc_upd;
            end else begin
              phd_crc <= ~crc_upd;
            end
            state <= EOT;
          end
        end

        EOT: begin
          state <= sel_req ? DONE : IDLE;
        end

        DONE: begin
          // Hold off until the inserter releases the request to avoid a refetch.
          if (!sel_req) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cr_prefix_attach_pfetch.sv
// Directed bench for cr_prefix_attach_pfetch with a cycle-stamped scoreboard
// of expected reads and EOT/CRC events.
module tb_cr_prefix_attach_pfetch;

  localparam int PHD_WORDS = 8;
  localparam int PFD_WORDS = 16;
  localparam int ADDR_W    = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              insert_phd_req, insert_pfd_req;
  logic              insert_phd_inwrk, insert_pfd_inwrk;
  logic [5:0]        prefix_num;
  logic [63:0]       phd_mem_dout = '0;
  logic [63:0]       pfd_mem_dout = '0;
  logic              phd_mem_rd, pfd_mem_rd;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              phd_dout_valid, pfd_dout_valid;
  logic              phd_eot, pfd_eot;
  logic [31:0]       phd_crc, pfd_crc;

  always #5 clk = ~clk;

  cr_prefix_attach_pfetch #(
    .PHD_WORDS(PHD_WORDS), .PFD_WORDS(PFD_WORDS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .insert_phd_req(insert_phd_req), .insert_pfd_req(insert_pfd_req),
    .insert_phd_inwrk(insert_phd_inwrk), .insert_pfd_inwrk(insert_pfd_inwrk),
    .prefix_num(prefix_num),
    .phd_mem_dout(phd_mem_dout), .pfd_mem_dout(pfd_mem_dout),
    .phd_mem_rd(phd_mem_rd), .pfd_mem_rd(pfd_mem_rd), .mem_rd_addr(mem_rd_addr),
    .phd_dout_valid(phd_dout_valid), .pfd_dout_valid(pfd_dout_valid),
    .phd_eot(phd_eot), .pfd_eot(pfd_eot),
    .phd_crc(phd_crc), .pfd_crc(pfd_crc)
  );

  // Memory models: one-cycle read latency.
  logic [63:0] phd_mem [0:1023];
  logic [63:0] pfd_mem [0:1023];
  always @(posedge clk) begin
    if (phd_mem_rd) phd_mem_dout <= phd_mem[mem_rd_addr];
    if (pfd_mem_rd) pfd_mem_dout <= pfd_mem[mem_rd_addr];
  end

  typedef struct { int cyc; logic sel; logic [ADDR_W-1:0] addr; } rd_exp_t;
  typedef struct { int cyc; logic sel; logic [31:0] crc; } eot_exp_t;
  rd_exp_t  rd_q[$];
  eot_exp_t eot_q[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc_cnt = 0;
  int          phd_eot_count = 0;
  int          pfd_eot_count = 0;
  logic        mon_en = 1'b0;
  logic [31:0] held_phd_crc = '0;
  logic [31:0] held_pfd_crc = '0;
  logic [31:0] saved_crc;

  function automatic logic [31:0] model_crc64(input logic [31:0] c, input logic [63:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 64; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc_cnt);
    end
  endtask

  // Drop expectations scheduled after cycle c (abort or reset).
  task automatic flush_after(input int c);
    while (rd_q.size() > 0 && rd_q[$].cyc > c) void'(rd_q.pop_back());
    while (eot_q.size() > 0 && eot_q[$].cyc > c) void'(eot_q.pop_back());
  endtask

  // Start seen in the current cycle: schedule reads, and the EOT with model CRC.
  task automatic launch(input logic s, input logic [5:0] pn);
    int          n;
    int          a;
    logic [31:0] c;
    rd_exp_t     re;
    eot_exp_t    ee;
    n = s ? PFD_WORDS : PHD_WORDS;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      a = s ? (int'(pn) * PFD_WORDS + i) : i;
      re.cyc = cyc_cnt + 1 + i; re.sel = s; re.addr = ADDR_W'(a);
      rd_q.push_back(re);
      c = model_crc64(c, s ? pfd_mem[a] : phd_mem[a]);
    end
    ee.cyc = cyc_cnt + n + 2; ee.sel = s; ee.crc = ~c;
    eot_q.push_back(ee);
    $display("launch %s prefix=%0d at cycle %0d exp_crc=%08h", s ? "PFD" : "PHD", pn, cyc_cnt, ~c);
  endtask

  // Advance one cycle and check all outputs against the scoreboard.
  task automatic cyc_step();
    logic lr, lpr, lfr, exp_rd, exp_eot;
    lr  = rst;
    lpr = phd_mem_rd;
    lfr = pfd_mem_rd;
    @(negedge clk);
    cyc_cnt++;
    if (lr) begin
      flush_after(cyc_cnt - 1);
      held_phd_crc = '0;
      held_pfd_crc = '0;
    end
    if (mon_en) begin
      check("phd_valid", phd_dout_valid, lpr & ~lr);
      check("pfd_valid", pfd_dout_valid, lfr & ~lr);
      check("exclusive",
            {(phd_mem_rd | phd_dout_valid | phd_eot) & (pfd_mem_rd | pfd_dout_valid | pfd_eot),
             (phd_eot | pfd_eot) & (phd_dout_valid | pfd_dout_valid)}, 2'b00);
      exp_rd = (rd_q.size() > 0) && (rd_q[0].cyc == cyc_cnt);
      check("rd_en", {phd_mem_rd, pfd_mem_rd},
            exp_rd ? (rd_q[0].sel ? 2'b01 : 2'b10) : 2'b00);
      if (exp_rd) begin
        if (phd_mem_rd | pfd_mem_rd) begin
          check("rd_addr", mem_rd_addr, rd_q[0].addr);
          $display("cycle %0d read %s addr=%0d", cyc_cnt, rd_q[0].sel ? "PFD" : "PHD", mem_rd_addr);
        end
        void'(rd_q.pop_front());
      end
      exp_eot = (eot_q.size() > 0) && (eot_q[0].cyc == cyc_cnt);
      check("eot", {phd_eot, pfd_eot},
            exp_eot ? (eot_q[0].sel ? 2'b01 : 2'b10) : 2'b00);
      if (exp_eot) begin
        if (eot_q[0].sel) held_pfd_crc = eot_q[0].crc;
        else              held_phd_crc = eot_q[0].crc;
        $display("cycle %0d eot %s crc=%08h", cyc_cnt, eot_q[0].sel ? "PFD" : "PHD",
                 eot_q[0].sel ? pfd_crc : phd_crc);
        void'(eot_q.pop_front());
      end
      check("phd_crc", phd_crc, held_phd_crc);
      check("pfd_crc", pfd_crc, held_pfd_crc);
      if (phd_eot) phd_eot_count++;
      if (pfd_eot) pfd_eot_count++;
    end
  endtask

  int eot_before;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      phd_mem[i] = 64'(i);
      pfd_mem[i] = {32'(i) ^ 32'hDEAD_BEEF, 32'(i) * 32'h0100_0193};
    end
    rst = 1'b1;
    insert_phd_req = 0; insert_pfd_req = 0;
    insert_phd_inwrk = 0; insert_pfd_inwrk = 0;
    prefix_num = '0;

    // Reset state
    repeat (3) cyc_step();
    check("rst_strobes", {phd_mem_rd, pfd_mem_rd, phd_dout_valid, pfd_dout_valid, phd_eot, pfd_eot}, 0);
    check("rst_addr", mem_rd_addr, 0);
    check("rst_crc", {phd_crc, pfd_crc}, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // PHD fetch, words 0..7
    cyc_step();
    insert_phd_req = 1; insert_phd_inwrk = 1;
    launch(1'b0, 6'd0);
    repeat (11) cyc_step();
    insert_phd_req = 0; insert_phd_inwrk = 0;

    // PFD fetch of the last prefix (addresses 1008..1023)
    cyc_step();
    insert_pfd_req = 1; insert_pfd_inwrk = 1; prefix_num = 6'd63;
    launch(1'b1, 6'd63);
    repeat (19) cyc_step();
    insert_pfd_req = 0; insert_pfd_inwrk = 0;

    // Simultaneous start: PHD first, PFD once the PHD request drops
    cyc_step();
    insert_phd_req = 1; insert_phd_inwrk = 1;
    insert_pfd_req = 1; insert_pfd_inwrk = 1; prefix_num = 6'd5;
    launch(1'b0, 6'd0);
    repeat (11) cyc_step();
    insert_phd_req = 0; insert_phd_inwrk = 0;
    cyc_step();
    launch(1'b1, 6'd5);
    repeat (19) cyc_step();
    insert_pfd_req = 0; insert_pfd_inwrk = 0;

    // Request held 20 cycles past EOT: single burst, single EOT
    cyc_step();
    eot_before = phd_eot_count;
    insert_phd_req = 1; insert_phd_inwrk = 1;
    launch(1'b0, 6'd0);
    repeat (31) cyc_step();
    check("held_eot_once", phd_eot_count - eot_before, 1);
    insert_phd_req = 0; insert_phd_inwrk = 0;

    // Abort in the third READ cycle, restart two cycles later
    cyc_step();
    insert_pfd_req = 1; insert_pfd_inwrk = 1; prefix_num = 6'd17;
    saved_crc = held_pfd_crc;
    launch(1'b1, 6'd17);
    repeat (3) cyc_step();
    insert_pfd_req = 0; insert_pfd_inwrk = 0;
    flush_after(cyc_cnt);
    repeat (2) cyc_step();
    check("abort_crc_kept", pfd_crc, saved_crc);
    insert_pfd_req = 1; insert_pfd_inwrk = 1;
    launch(1'b1, 6'd17);
    repeat (19) cyc_step();
    insert_pfd_req = 0; insert_pfd_inwrk = 0;

    // Reset during DRAIN, then a clean PHD fetch
    cyc_step();
    insert_phd_req = 1; insert_phd_inwrk = 1;
    launch(1'b0, 6'd0);
    repeat (9) cyc_step();
    rst = 1'b1;
    insert_phd_req = 0; insert_phd_inwrk = 0;
    cyc_step();
    check("drain_rst_strobes", {phd_mem_rd, pfd_mem_rd, phd_dout_valid, pfd_dout_valid, phd_eot, pfd_eot}, 0);
    check("drain_rst_crc", {phd_crc, pfd_crc}, 0);
    rst = 1'b0;
    cyc_step();
    insert_phd_req = 1; insert_phd_inwrk = 1;
    launch(1'b0, 6'd0);
    repeat (11) cyc_step();
    insert_phd_req = 0; insert_phd_inwrk = 0;
    repeat (4) cyc_step();

    check("phd_eot_total", phd_eot_count, 4);
    check("pfd_eot_total", pfd_eot_count, 3);
    check("scoreboard_empty", rd_q.size() + eot_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
